csla_bist: RTL
==============

# csla_bist

On-chip built-in self-test controller for the 64-bit carry-select adder `csla_64bit`. It is the driving and checking end of the adder interface: it generates `a`/`b`/`cin` operands (four fixed corner vectors, then LFSR pseudo-random vectors) and waits a programmable settle time. It then compares the adder's `sum`/`cout` against an internal golden `a+b+cin` and reports pass/fail, error count and first failing vector. It sits beside the adder in the test wrapper and replaces the simulation-only testbench for silicon and gate-level checks.

## Interface
- `NUM_VECTORS`, default 1024: total vectors applied, including the 4 corner vectors; legal range 4..65535.
- `SETTLE_CYCLES`, default 2: cycles the operands are held before the result is sampled; legal range ≥1.
- `SEED_A`, default 64'h0123_4567_89AB_CDEF: LFSR A seed; a zero value is replaced by 1.
- `SEED_B`, default 64'hFEDC_BA98_7654_3210: LFSR B seed; a zero value is replaced by 1.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  starts a run when sampled high in IDLE or DONE.
- `dut_a`  out  64  operand a to adder (registered).
- `dut_b`  out  64  operand b to adder (registered).
- `dut_cin`  out  1  carry-in to adder (registered).
- `dut_sum`  in  64  adder sum.
- `dut_cout`  in  1  adder carry-out.
- `busy`  out  1  high in LOAD/SETTLE/CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`; 1 iff `err_count`==0.
- `err_count`  out  16  mismatching vectors; saturates at 16'hFFFF.
- `first_fail_idx`  out  16  index of the first mismatch; 16'hFFFF if none.

## Operation
- Reset values: `dut_a`=0, `dut_b`=0, `dut_cin`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_idx`=16'hFFFF, FSM=IDLE, vector index=0, LFSRs=seeds.
- FSM states:
  - IDLE: on `start` go to LOAD; clear counters; reseed the LFSRs.
  - LOAD (1 cycle): register vector[idx] onto the `dut_*` outputs; register the expected 65-bit result {cout,sum} = a+b+cin, computed at full width with no truncation before the compare.
  - SETTLE: hold for `SETTLE_CYCLES` cycles via a down-counter.
  - CHECK (1 cycle): compare {`dut_cout`,`dut_sum`} with the expected value.
    - On mismatch: increment `err_count` (saturating); if `first_fail_idx`==16'hFFFF, load it with idx.
    - If idx==NUM_VECTORS-1, go to DONE. Otherwise increment idx, advance the LFSRs if idx≥4, and go to LOAD.
  - DONE: hold all results and operands. `start` restarts the run (same path as from IDLE).
- Vectors:
  - idx0: a=0, b=0, cin=0.
  - idx1: a=all-ones, b=0, cin=1.
  - idx2: a=all-ones, b=all-ones, cin=1.
  - idx3: a=64'h8000_0000_0000_0000, b=same, cin=0.
  - idx≥4: a=LFSR A, b=LFSR B, cin=idx[0].
- LFSR: Fibonacci shift-left; new bit0 = q[63]^q[62]^q[60]^q[59]. Both LFSRs advance once per random vector, in CHECK.
- `start` while `busy` is ignored. `start` held high in DONE restarts on every sampled edge in DONE.
- `rst_n` asserted mid-run returns immediately to the reset values. No partial results are retained.

## Timing
- Each vector takes 1 (LOAD) + SETTLE_CYCLES + 1 (CHECK) cycles.
- `start` sampled at edge 0 → `busy` is high from edge 1.
- `done` rises NUM_VECTORS×(SETTLE_CYCLES+2)+1 edges after the `start` sample; `busy` falls on the same edge.
- Operands change only on LOAD edges and are stable for SETTLE_CYCLES+1 cycles before the CHECK sample.
- `err_count`, `first_fail_idx` and `pass` update on CHECK/DONE edges; `pass` is 0 whenever `done`=0.

## Test plan
- Correct behavioural adder, NUM_VECTORS=8, SETTLE_CYCLES=2, `start` pulsed → `done` rises at edge 33; `pass`=1, `err_count`=0, `first_fail_idx`=16'hFFFF.
- Correct adder, monitor `dut_*` → idx1 expects sum=0, cout=1; idx2 expects sum=64'hFFFF_FFFF_FFFF_FFFF, cout=1; idx3 expects sum=0, cout=1; no errors.
- `dut_cout` stuck at 0 → `first_fail_idx`=1, `err_count`≥3, `pass`=0.
- `dut_sum[0]` stuck at 1 → `first_fail_idx`=0, `err_count`≥1, `pass`=0.
- `rst_n` pulsed low at vector 5, then `start` → all outputs at reset values during reset; the rerun gives results identical to the uninterrupted run.
- `start` re-pulsed while `busy` → ignored, completion time unchanged. `start` in DONE → new run; `err_count` cleared, identical operand sequence.

Source files
------------

// File: rtl/csla_bist.sv
// Built-in self-test driver/checker for a 64-bit adder: applies corner then LFSR vectors,
// waits a programmable settle time and compares {cout,sum} against a full-width golden sum.
module csla_bist #(
  parameter int unsigned NUM_VECTORS   = 1024,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [63:0] SEED_A        = 64'h0123_4567_89AB_CDEF,
  parameter logic [63:0] SEED_B        = 64'hFEDC_BA98_7654_3210
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [63:0] dut_a,
  output logic [63:0] dut_b,
  output logic        dut_cin,
  input  logic [63:0] dut_sum,
  input  logic        dut_cout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_idx
);

  localparam logic [63:0] SEED_A_EFF  = (SEED_A == 64'd0) ? 64'd1 : SEED_A;
  localparam logic [63:0] SEED_B_EFF  = (SEED_B == 64'd0) ? 64'd1 : SEED_B;
  localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
  localparam logic [31:0] SETTLE_INIT = 32'(SETTLE_CYCLES - 1);
  localparam logic [15:0] NO_FAIL     = 16'hFFFF;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [63:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [63:0] a_q, a_d, b_q, b_d;
  logic        cin_q, cin_d;
  logic [64:0] exp_q, exp_d;
  logic [15:0] err_q, err_d, ffi_q, ffi_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic [63:0] vec_a, vec_b;
  logic        vec_cin;

  function automatic logic [63:0] lfsr_next(input logic [63:0] q);
    return {q[62:0], q[63] ^ q[62] ^ q[60] ^ q[59]};
  endfunction

  // Four corner vectors exercise full carry ripple and top-bit overflow before random patterns.
  always_comb begin
    vec_a   = lfsr_a_q;
    vec_b   = lfsr_b_q;
    vec_cin = idx_q[0];
    case (idx_q)
      16'd0: begin vec_a = 64'd0;  vec_b = 64'd0;  vec_cin = 1'b0; end
      16'd1: begin vec_a = '1;     vec_b = 64'd0;  vec_cin = 1'b1; end
      16'd2: begin vec_a = '1;     vec_b = '1;     vec_cin = 1'b1; end
      16'd3: begin vec_a = 64'h8000_0000_0000_0000; vec_b = 64'h8000_0000_0000_0000; vec_cin = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    exp_d    = exp_q;
    err_d    = err_q;
    ffi_d    = ffi_q;
    // Status outputs are registered, so they trail the state by one edge.
    busy_d   = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    done_d   = (state_q == S_DONE);
    pass_d   = (state_q == S_DONE) && (err_q == 16'd0);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_LOAD;
          idx_d    = 16'd0;
          err_d    = 16'd0;
          ffi_d    = NO_FAIL;
          lfsr_a_d = SEED_A_EFF;
          lfsr_b_d = SEED_B_EFF;
        end
      end
      S_LOAD: begin
        a_d     = vec_a;
        b_d     = vec_b;
        cin_d   = vec_cin;
        exp_d   = {1'b0, vec_a} + {1'b0, vec_b} + {64'd0, vec_cin};
        cnt_d   = SETTLE_INIT;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 32'd0) state_d = S_CHECK;
        else                cnt_d   = cnt_q - 32'd1;
      end
      S_CHECK: begin
        if ({dut_cout, dut_sum} != exp_q) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (ffi_q == NO_FAIL)  ffi_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_LOAD;
          if (idx_q >= 16'd4) begin
            lfsr_a_d = lfsr_next(lfsr_a_q);
            lfsr_b_d = lfsr_next(lfsr_b_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 16'd0;
      cnt_q    <= 32'd0;
      lfsr_a_q <= SEED_A_EFF;
      lfsr_b_q <= SEED_B_EFF;
      a_q      <= 64'd0;
      b_q      <= 64'd0;
      cin_q    <= 1'b0;
      exp_q    <= 65'd0;
      err_q    <= 16'd0;
      ffi_q    <= NO_FAIL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
      ffi_q    <= ffi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_a          = a_q;
  assign dut_b          = b_q;
  assign dut_cin        = cin_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;

endmodule
